// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for the 5-stage RV32IM pipeline: drives stage-latch loads/valids and PC load.
// Optional stall/flush performance counters are built only when STALL_PERF_EN is defined.
module pipeline_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_mul,
    input  logic             ex_is_div,
    input  logic             ex_mispredict,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             if_id_valid,
    output logic             id_ex_valid,
    output logic             ex_mem_valid,
    output logic             muldiv_done,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] perf_mem_stall,
    output logic [CNT_W-1:0] perf_md_stall,
    output logic [CNT_W-1:0] perf_lu_stall,
    output logic [CNT_W-1:0] perf_flush
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_MULDIV = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_md_done_flag;
    logic            w_md_done_flag_nxt;

    logic w_md_counting;
    logic w_md_last;
    logic w_mop_req;
    logic w_md_start;
    logic w_lu_hazard;

    assign w_md_counting = (r_state == S_MULDIV) && (r_cnt != '0);
    assign w_md_last     = (r_state == S_MULDIV) && (r_cnt == '0);
    assign w_mop_req     = ex_valid & (ex_is_mul | ex_is_div) & ~r_md_done_flag;
    // The final MULDIV cycle uses RUN rules but must never restart the same op.
    assign w_md_start    = (r_state == S_RUN) & ~dmem_stall & w_mop_req;
    assign w_lu_hazard   = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
                           ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                            (id_uses_rs2 & (id_rs2 == ex_rd)));

    assign muldiv_done = w_md_last;
    assign muldiv_busy = (r_state == S_MULDIV);

    always_comb begin
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        id_ex_load   = 1'b1;
        ex_mem_load  = 1'b1;
        mem_wb_load  = 1'b1;
        if_id_valid  = 1'b1;
        id_ex_valid  = 1'b1;
        ex_mem_valid = 1'b1;
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;

        if (w_md_counting) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            ex_mem_valid = 1'b0;
            w_cnt_nxt    = r_cnt - CW'(1);
            if (dmem_stall) begin
                pc_load     = 1'b0;
                if_id_load  = 1'b0;
                id_ex_load  = 1'b0;
                ex_mem_load = 1'b0;
                mem_wb_load = 1'b0;
            end
        end else begin
            if (r_state == S_MULDIV) begin
                w_state_nxt = S_RUN;
            end
            if (dmem_stall) begin
                pc_load     = 1'b0;
                if_id_load  = 1'b0;
                id_ex_load  = 1'b0;
                ex_mem_load = 1'b0;
                mem_wb_load = 1'b0;
            end else if (w_md_start) begin
                pc_load      = 1'b0;
                if_id_load   = 1'b0;
                id_ex_load   = 1'b0;
                ex_mem_valid = 1'b0;
                w_state_nxt  = S_MULDIV;
                w_cnt_nxt    = ex_is_div ? CW'(DIV_CYCLES - 2) : CW'(MUL_CYCLES - 2);
            end else if (ex_mispredict) begin
                if_id_valid = 1'b0;
                id_ex_valid = 1'b0;
            end else if (w_lu_hazard) begin
                pc_load     = 1'b0;
                if_id_load  = 1'b0;
                id_ex_valid = 1'b0;
            end else if (imem_stall) begin
                pc_load     = 1'b0;
                if_id_valid = 1'b0;
            end
        end
    end

    // A finished op held in EX by a dcache stall must not restart once the stall clears.
    always_comb begin
        w_md_done_flag_nxt = r_md_done_flag;
        if (w_md_last & dmem_stall) begin
            w_md_done_flag_nxt = 1'b1;
        end else if (ex_mem_load) begin
            w_md_done_flag_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_RUN;
            r_cnt          <= '0;
            r_md_done_flag <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_md_done_flag <= w_md_done_flag_nxt;
        end
    end

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] r_perf_mem_stall;
    logic [CNT_W-1:0] r_perf_md_stall;
    logic [CNT_W-1:0] r_perf_lu_stall;
    logic [CNT_W-1:0] r_perf_flush;
    logic             w_flush_taken;
    logic             w_lu_taken;

    assign w_flush_taken = ~w_md_counting & ~dmem_stall & ~w_md_start & ex_mispredict;
    assign w_lu_taken    = ~w_md_counting & ~dmem_stall & ~w_md_start & ~ex_mispredict &
                           w_lu_hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_mem_stall <= '0;
            r_perf_md_stall  <= '0;
            r_perf_lu_stall  <= '0;
            r_perf_flush     <= '0;
        end else begin
            if (dmem_stall)                  r_perf_mem_stall <= r_perf_mem_stall + CNT_W'(1);
            if (muldiv_busy | w_md_start)    r_perf_md_stall  <= r_perf_md_stall + CNT_W'(1);
            if (w_lu_taken)                  r_perf_lu_stall  <= r_perf_lu_stall + CNT_W'(1);
            if (w_flush_taken)               r_perf_flush     <= r_perf_flush + CNT_W'(1);
        end
    end

    assign perf_mem_stall = r_perf_mem_stall;
    assign perf_md_stall  = r_perf_md_stall;
    assign perf_lu_stall  = r_perf_lu_stall;
    assign perf_flush     = r_perf_flush;
`else
    assign perf_mem_stall = '0;
    assign perf_md_stall  = '0;
    assign perf_lu_stall  = '0;
    assign perf_flush     = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: single-cycle priority table in RUN, then multi-cycle
// multiply, divide-with-dcache-stall, reset-mid-divide and perf counter sequences.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_stall, dmem_stall, id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_valid, ex_is_load, ex_is_mul, ex_is_div, ex_mispredict;
    logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_valid, id_ex_valid, ex_mem_valid, muldiv_done, muldiv_busy;
    logic [31:0] perf_mem_stall, perf_md_stall, perf_lu_stall, perf_flush;

    pipeline_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(33), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_is_mul(ex_is_mul), .ex_is_div(ex_is_div), .ex_mispredict(ex_mispredict),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_valid(if_id_valid), .id_ex_valid(id_ex_valid), .ex_mem_valid(ex_mem_valid),
        .muldiv_done(muldiv_done), .muldiv_busy(muldiv_busy),
        .perf_mem_stall(perf_mem_stall), .perf_md_stall(perf_md_stall),
        .perf_lu_stall(perf_lu_stall), .perf_flush(perf_flush)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb loads, if_id/id_ex/ex_mem valids, done, busy}
    logic [9:0] obs;
    assign obs = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                  if_id_valid, id_ex_valid, ex_mem_valid, muldiv_done, muldiv_busy};

    localparam logic [9:0] ALL_RUN = 10'b11111_111_00;

    int n_pass  = 0;
    int n_total = 0;

`ifdef STALL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic set_idle();
        imem_stall = 0; dmem_stall = 0; id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_valid = 0; ex_is_load = 0;
        ex_is_mul = 0; ex_is_div = 0; ex_mispredict = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_idle();
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    typedef struct {
        string      name;
        logic       imem, dmem, idv;
        logic [4:0] rs1, rs2;
        logic       u1, u2, exv, ld;
        logic [4:0] rd;
        logic       mis;
        logic [9:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string n, input logic imem, input logic dmem, input logic idv,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                           input logic u2, input logic exv, input logic ld, input logic [4:0] rd,
                           input logic mis, input logic [9:0] exp);
        vec_t v;
        v.name = n; v.imem = imem; v.dmem = dmem; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.exv = exv; v.ld = ld; v.rd = rd; v.mis = mis; v.exp = exp;
        vq.push_back(v);
    endtask

    initial begin
        int bubbles;
        int dones;
        logic [3:0] mul_exp [4];

        //            name           im dm idv rs1 rs2 u1 u2 exv ld rd  mis expected
        add_vec("idle",           0, 0, 0,  0,  0, 0, 0, 0,  0, 0,  0, ALL_RUN);
        add_vec("dmem",           0, 1, 0,  0,  0, 0, 0, 0,  0, 0,  0, 10'b00000_111_00);
        add_vec("mispredict",     0, 0, 0,  0,  0, 0, 0, 0,  0, 0,  1, 10'b11111_001_00);
        add_vec("mis_imem",       1, 0, 0,  0,  0, 0, 0, 0,  0, 0,  1, 10'b11111_001_00);
        add_vec("lu_rs2",         0, 0, 1,  0,  5, 0, 1, 1,  1, 5,  0, 10'b00111_101_00);
        add_vec("lu_rd0",         0, 0, 1,  0,  0, 0, 1, 1,  1, 0,  0, ALL_RUN);
        add_vec("lu_rs1_unused",  0, 0, 1,  7,  0, 0, 0, 1,  1, 7,  0, ALL_RUN);
        add_vec("lu_rs1",         0, 0, 1,  7,  0, 1, 0, 1,  1, 7,  0, 10'b00111_101_00);
        add_vec("lu_no_idv",      0, 0, 0,  7,  0, 1, 0, 1,  1, 7,  0, ALL_RUN);
        add_vec("lu_no_exv",      0, 0, 1,  7,  0, 1, 0, 0,  1, 7,  0, ALL_RUN);
        add_vec("imem",           1, 0, 0,  0,  0, 0, 0, 0,  0, 0,  0, 10'b01111_011_00);
        add_vec("lu_over_imem",   1, 0, 1,  7,  0, 1, 0, 1,  1, 7,  0, 10'b00111_101_00);
        add_vec("dmem_over_mis",  0, 1, 0,  0,  0, 0, 0, 0,  0, 0,  1, 10'b00000_111_00);
        add_vec("mis_over_lu",    0, 0, 1,  7,  0, 1, 0, 1,  1, 7,  1, 10'b11111_001_00);
        add_vec("rd_match_noload",0, 0, 1,  0,  9, 0, 1, 1,  0, 9,  0, ALL_RUN);
        add_vec("dmem_over_lu",   0, 1, 1,  7,  0, 1, 0, 1,  1, 7,  0, 10'b00000_111_00);

        // Reset values and outputs while reset is held
        rst = 1'b0;
        set_idle();
        #1;
        chk("reset_outputs", 32'(obs), 32'(ALL_RUN));
        chk("reset_perf_mem", perf_mem_stall, 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // Single-cycle priority table in RUN
        foreach (vq[i]) begin
            imem_stall = vq[i].imem; dmem_stall = vq[i].dmem; id_valid = vq[i].idv;
            id_rs1 = vq[i].rs1; id_rs2 = vq[i].rs2; id_uses_rs1 = vq[i].u1;
            id_uses_rs2 = vq[i].u2; ex_valid = vq[i].exv; ex_is_load = vq[i].ld;
            ex_rd = vq[i].rd; ex_mispredict = vq[i].mis;
            #1;
            chk(vq[i].name, 32'(obs), 32'(vq[i].exp));
            next_cycle();
        end

        // Perf counters: 7 dcache stall cycles, 2 flushes, 1 load-use stall
        do_reset();
        next_cycle();
        dmem_stall = 1;
        repeat (7) next_cycle();
        dmem_stall = 0; ex_mispredict = 1;
        repeat (2) next_cycle();
        ex_mispredict = 0;
        id_valid = 1; id_rs2 = 5; id_uses_rs2 = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 5;
        next_cycle();
        set_idle();
        #1;
        chk("perf_mem_stall", perf_mem_stall, PERF_ON ? 32'd7 : 32'd0);
        chk("perf_flush", perf_flush, PERF_ON ? 32'd2 : 32'd0);
        chk("perf_lu_stall", perf_lu_stall, PERF_ON ? 32'd1 : 32'd0);
        next_cycle();

        // Multiply: per cycle {id_ex_load, ex_mem_valid, done, busy}
        mul_exp[0] = 4'b0000;
        mul_exp[1] = 4'b0001;
        mul_exp[2] = 4'b0001;
        mul_exp[3] = 4'b1111;
        bubbles = 0;
        ex_valid = 1; ex_is_mul = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("mul_cycle%0d", c + 1),
                32'({id_ex_load, ex_mem_valid, muldiv_done, muldiv_busy}), 32'(mul_exp[c]));
            if (ex_mem_load && !ex_mem_valid) bubbles++;
            next_cycle();
        end
        chk("mul_bubbles", 32'(bubbles), 32'd3);
        set_idle();
        #1;
        chk("mul_back_to_run", 32'(obs), 32'(ALL_RUN));
        chk("perf_md_stall", perf_md_stall, PERF_ON ? 32'd4 : 32'd0);
        next_cycle();

        // Divide with a dcache stall on its final cycle
        dones = 0;
        ex_valid = 1; ex_is_div = 1;
        for (int c = 1; c <= 32; c++) begin
            #1;
            if (muldiv_done) dones++;
            if (c == 2) chk("div_busy_early", 32'({id_ex_load, muldiv_busy}), 32'b01);
            next_cycle();
        end
        chk("div_no_early_done", 32'(dones), 32'd0);
        dmem_stall = 1;
        #1;
        chk("div_last_dmem", 32'(obs), 32'(10'b00000_111_11));
        next_cycle();
        #1;
        chk("div_held_dmem", 32'(obs), 32'(10'b00000_111_00));
        next_cycle();
        dmem_stall = 0;
        #1;
        chk("div_advance_no_restart", 32'(obs), 32'(ALL_RUN));
        next_cycle();
        set_idle();
        #1;
        chk("div_after", 32'(obs), 32'(ALL_RUN));
        next_cycle();

        // Reset mid-divide at cnt == 10
        dones = 0;
        ex_valid = 1; ex_is_div = 1;
        next_cycle();
        for (int c = 2; c <= 22; c++) begin
            #1;
            if (muldiv_done) dones++;
            next_cycle();
        end
        #1;
        chk("rstdiv_busy_before", 32'({muldiv_busy, muldiv_done}), 32'b10);
        chk("rstdiv_no_done", 32'(dones), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("rstdiv_async", 32'({muldiv_busy, muldiv_done}), 32'b00);
        set_idle();
        #1;
        chk("rstdiv_idle_outputs", 32'(obs), 32'(ALL_RUN));
        next_cycle();
        #1;
        chk("rstdiv_perf_zero", perf_md_stall, 32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        #1;
        chk("rstdiv_after_release", 32'(obs), 32'(ALL_RUN));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and stall sequencer for the 5-stage RV32IM pipeline. It drives the `load` and inserted-`valid` inputs of the four `stage_latch` instances (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register load.

It arbitrates between four events:
- data-cache stalls;
- multi-cycle multiply/divide occupancy of EX;
- load-use hazards;
- branch-misprediction squashes.

Control outputs are combinational from current state and inputs. Sequencing state is registered.

## Interface
- `MUL_CYCLES`, default 4: total EX occupancy of a multiply, in cycles; must be ≥2.
- `DIV_CYCLES`, default 33: total EX occupancy of a divide/remainder, in cycles; must be ≥2.
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; **asynchronous, active-low**.
- `imem_stall`  in  1  icache miss outstanding; the fetched word is not valid.
- `dmem_stall`  in  1  dcache access in MEM not complete.
- `id_valid`  in  1  IF/ID holds a valid instruction.
- `id_rs1`, `id_rs2`  in  5  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1  the instruction in ID reads that source.
- `ex_valid`  in  1  ID/EX holds a valid instruction.
- `ex_is_load`  in  1  the EX instruction is a load.
- `ex_rd`  in  5  destination register of the EX instruction.
- `ex_is_mul`, `ex_is_div`  in  1  the EX instruction is an M-extension multiply / divide.
- `ex_mispredict`  in  1  the EX branch/jump resolved against its prediction.
- `pc_load`  out  1  PC register load.
- `if_id_load`, `id_ex_load`, `ex_mem_load`, `mem_wb_load`  out  1  stage latch loads.
- `if_id_valid`, `id_ex_valid`, `ex_mem_valid`  out  1  valid bit written into the latch when its load is 1; 0 inserts a bubble.
- `muldiv_done`  out  1  pulse: the M-unit result is final this cycle.
- `muldiv_busy`  out  1  state is `MULDIV`.
- `perf_mem_stall`, `perf_md_stall`, `perf_lu_stall`, `perf_flush`  out  `CNT_W`  stall/flush event counters.

## Operation
- **States.**
  - `RUN`: normal.
  - `MULDIV`: EX occupied by a counting M-op.
- **Registered state.** `state`; down-counter `cnt` of width clog2(max(MUL_CYCLES, DIV_CYCLES)); flag `md_done_flag`.
- **Default.** All loads = 1 and all valids = 1.
- **Evaluation in `RUN`**, in priority order:
  1. `dmem_stall`: all loads = 0.
  2. M-op start, when `ex_valid & (ex_is_mul|ex_is_div) & !md_done_flag`:
     - `pc_load`, `if_id_load`, `id_ex_load` = 0;
     - `ex_mem_load` = 1 with `ex_mem_valid` = 0;
     - `mem_wb_load` = 1;
     - `cnt` ← `MUL_CYCLES-2` or `DIV_CYCLES-2`; `state` → `MULDIV`.
  3. `ex_mispredict`: all loads = 1; `if_id_valid` = `id_ex_valid` = 0 (squash two younger instructions); `perf_flush`++.
  4. Load-use, when `ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`:
     - `pc_load` = `if_id_load` = 0;
     - `id_ex_load` = 1 with `id_ex_valid` = 0.
  5. `imem_stall`: `pc_load` = 0; `if_id_load` = 1 with `if_id_valid` = 0.
- **`MULDIV`, while `cnt` != 0:**
  - `pc_load`, `if_id_load`, `id_ex_load` = 0;
  - `ex_mem_load` = 1 with `ex_mem_valid` = 0;
  - `mem_wb_load` = 1;
  - `cnt`--.
  - `dmem_stall` forces all loads = 0; `cnt` still decrements.
- **`MULDIV`, when `cnt` == 0:**
  - `muldiv_done` = 1; `state` → `RUN`.
  - Outputs evaluate per `RUN` rules, with rule 2 suppressed.
  - If `dmem_stall` is 1 this cycle, set `md_done_flag`.
- **`md_done_flag`** clears on any cycle with `ex_mem_load=1`.
- **Simultaneous events.**
  - `dmem_stall` overrides everything.
  - A mispredicting instruction is never an M-op.
  - A mispredict and `imem_stall` together give `pc_load=1`; the redirect wins and the icache discards the stale miss.

## Timing
- **Reset values.** `rst` low → `state`=`RUN`, `cnt`=0, `md_done_flag`=0, all perf counters 0.
- **Outputs during reset.** Loads=1, valids=1, `muldiv_done`=0, `muldiv_busy`=0, for idle inputs.
- **Mid-operation reset.** Abandons `MULDIV` immediately, with no `muldiv_done` pulse.
- **Zero-latency decisions.** No output has a registered delay relative to the inputs.
- **M-op occupancy.** An uninterrupted M-op holds EX for exactly `MUL_CYCLES` / `DIV_CYCLES` cycles. `muldiv_done` is asserted in the last of these, and the op enters EX/MEM at the end of that cycle.
- **Load-use.** A load-use hazard costs exactly one bubble cycle.
- **Mispredict.** A mispredict costs two bubbles.

## Configuration
- **`STALL_PERF_EN` defined:** counters increment once per cycle of the matching condition, wrapping at 2^`CNT_W`.
  - `perf_mem_stall`: `dmem_stall`.
  - `perf_md_stall`: `muldiv_busy`, plus the start cycle.
  - `perf_lu_stall`: load-use rule taken.
  - `perf_flush`: mispredict rule taken.
- **`STALL_PERF_EN` undefined:** counter registers are not instantiated and all `perf_*` outputs are tied to 0.

## Test plan
- **Multiply:** `ex_valid=1`, `ex_is_mul=1`, `MUL_CYCLES=4` → `id_ex_load` = 0 for 3 cycles; `muldiv_done` pulses on cycle 4; `id_ex_load` = 1 on cycle 4; exactly 3 EX/MEM bubbles.
- **Load-use:** `ex_is_load=1`, `ex_rd=5`, `id_rs2=5`, `id_uses_rs2=1` → one cycle with `pc_load=0`, `if_id_load=0`, `id_ex_valid=0`. Repeat with `ex_rd=0` → no stall.
- **Mispredict:** `ex_mispredict=1` with `imem_stall=1` → `pc_load=1`, `if_id_valid=0`, `id_ex_valid=0`, `ex_mem_valid=1`.
- **Divide with memory stall:** `DIV_CYCLES=33` divide with `dmem_stall` high on the `cnt`==0 cycle → `md_done_flag` set, no restart; the op advances on the first cycle with `dmem_stall=0`.
- **Reset mid-divide:** `rst` low during a divide at `cnt`=10 → `state`=`RUN`, `muldiv_busy`=0 asynchronously; no `muldiv_done` pulse.
- **Perf counters (`STALL_PERF_EN`):** 7 cycles of `dmem_stall` → `perf_mem_stall`=7. Without the macro → 0.
